// File: rtl/host_to_breakout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : host_to_breakout_pkg
// Purpose  : Frame layout shared by the host-to-breakout receiver, the host
//            side model and the top level.
//            Data word: bits [7:0] = dout0..dout7 and bits [11:8] = led0..led3.
//            The first bit on the wire is bit 0.
// Ports    : none (package)
// Options  : H2B_PARITY_EN -- adds an even-parity bit, so each frame is 13 bits.
// Revision : 1.0 - initial release
// ============================================================================
package host_to_breakout_pkg;

  localparam int H2B_DATA_BITS  = 12;
  localparam int H2B_PORT_LSB   = 0;
  localparam int H2B_PORT_W     = 8;
  localparam int H2B_LED_LSB    = 8;
  localparam int H2B_LED_W      = 4;
  localparam int H2B_PARITY_IDX = H2B_DATA_BITS;

`ifdef H2B_PARITY_EN
  localparam int H2B_FRAME_BITS = H2B_DATA_BITS + 1;
`else
  localparam int H2B_FRAME_BITS = H2B_DATA_BITS;
`endif

  localparam int H2B_CNT_W = 4;

  // Even-parity bit that the host appends after the data bits.
  function automatic logic h2b_even_parity(input logic [H2B_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/h2b_wire_sync.sv
`default_nettype none
// ============================================================================
// Module   : h2b_wire_sync
// Purpose  : Brings an asynchronous serial clock and serial data pair into the
//            clk domain. Each input passes through a 2-FF synchronizer and then
//            one history FF. The module gives a one-cycle strobe for each
//            rising edge of the serial clock, together with the data bit.
// Ports    : clk       in  system clock
//            reset_n   in  synchronous reset, active low
//            wire_clk  in  asynchronous serial clock
//            wire_dat  in  asynchronous serial data (changes on the falling edge)
//            rise      out rising edge seen on the synchronized serial clock
//            data_bit  out data sampled for that edge
// Revision : 1.0 - initial release
// ============================================================================
module h2b_wire_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic wire_clk,
  input  logic wire_dat,
  output logic rise,
  output logic data_bit
);

  logic clk_s1, clk_s2, clk_hist;
  logic dat_s1, dat_s2, dat_hist;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_hist <= 1'b0;
      dat_s1   <= 1'b0;
      dat_s2   <= 1'b0;
      dat_hist <= 1'b0;
    end else begin
      clk_s1   <= wire_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= wire_dat;
      dat_s2   <= dat_s1;
      dat_hist <= dat_s2;
    end
  end

  assign rise = clk_s2 & ~clk_hist;
  // The data comes from the older history stage. The host changes data on
  // the falling edge, so at least two clk periods before the rising edge.
  // The sample is therefore settled well before the edge is detected.
  assign data_bit = dat_hist;

endmodule
`default_nettype wire

// File: rtl/host_to_breakout.sv
`default_nettype none
// ============================================================================
// Module   : host_to_breakout
// Purpose  : Receiver for the host-to-breakout serial link. It oversamples
//            the wire clock and data, then shifts the bits into frames, with
//            the first bit being dout0. Each good frame updates the outputs.
//            A long gap between wire-clock edges realigns the frame.
//            A watchdog drops o_link_up when good frames stop arriving.
// Ports    : i_clk        in  system clock (the only clock)
//            i_reset_n    in  synchronous reset, active low
//            i_wire_clk   in  host serial clock (asynchronous, <= i_clk/4)
//            i_q          in  host serial data
//            o_port[7:0]  out digital outputs, dout n on bit n
//            o_led[3:0]   out link LEDs, led n on bit n
//            o_valid      out one-cycle pulse when o_port/o_led are loaded
//            o_frame_err  out one-cycle pulse when a frame is discarded
//            o_link_up    out high while good frames keep arriving
// Options  : H2B_PARITY_EN -- 13-bit frames with an even-parity bit (bit 12).
//            A frame that fails parity is discarded.
// Revision : 1.0 - initial release
// ============================================================================
module host_to_breakout
  import host_to_breakout_pkg::*;
#(
  parameter int RST_THRESH       = 10,
  parameter int TIMEOUT_CYCLES   = 500_000,
  parameter int CLEAR_ON_TIMEOUT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wire_clk,
  input  logic                  i_q,
  output logic [H2B_PORT_W-1:0] o_port,
  output logic [H2B_LED_W-1:0]  o_led,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_link_up
);

  localparam int GAP_W = $clog2(RST_THRESH + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [H2B_CNT_W-1:0] CNT_LAST = H2B_CNT_W'(H2B_FRAME_BITS - 1);
  localparam logic [GAP_W-1:0]     GAP_MAX  = GAP_W'(RST_THRESH);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(RST_THRESH - 1);
  localparam logic [WD_W-1:0]      WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  logic                      rise;
  logic                      data_bit;
  logic [H2B_FRAME_BITS-1:0] shreg;
  logic [H2B_CNT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]          gap_cnt;
  logic [WD_W-1:0]           wd_cnt;
  logic                      frame_done;
  logic                      parity_ok;
  logic                      load;
  logic                      parity_err;

  h2b_wire_sync u_sync (
    .clk      (i_clk),
    .reset_n  (i_reset_n),
    .wire_clk (i_wire_clk),
    .wire_dat (i_q),
    .rise     (rise),
    .data_bit (data_bit)
  );

`ifdef H2B_PARITY_EN
  assign parity_ok = (h2b_even_parity(shreg[H2B_DATA_BITS-1:0]) == shreg[H2B_PARITY_IDX]);
`else
  assign parity_ok = 1'b1;
`endif

  // frame_done marks the cycle after the last bit is shifted in. The
  // completed frame is still in shreg, because the next wire edge is at
  // least four clk cycles away.
  assign load       = frame_done & parity_ok;
  assign parity_err = frame_done & ~parity_ok;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      frame_done  <= 1'b0;
      o_port      <= '0;
      o_led       <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_link_up   <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;

      // Shifting right puts the first wire bit at shreg[0] when the frame is complete.
      // A wire edge always takes priority over the gap threshold.
      if (rise) begin
        shreg   <= {data_bit, shreg[H2B_FRAME_BITS-1:1]};
        gap_cnt <= '0;
        if (bit_cnt == CNT_LAST) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (gap_cnt != GAP_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
        // The gap counter stays saturated until the next edge, so a partial
        // frame is reported at most once per gap.
        if (gap_cnt == GAP_LAST) begin
          bit_cnt <= '0;
          if (bit_cnt != '0) begin
            o_frame_err <= 1'b1;
          end
        end
      end

      if (parity_err) begin
        o_frame_err <= 1'b1;
      end

      // If a frame loads in the same cycle that the watchdog expires, the frame wins.
      if (load) begin
        o_port    <= shreg[H2B_PORT_LSB +: H2B_PORT_W];
        o_led     <= shreg[H2B_LED_LSB +: H2B_LED_W];
        o_valid   <= 1'b1;
        o_link_up <= 1'b1;
        wd_cnt    <= '0;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WD_LAST) begin
          o_link_up <= 1'b0;
          if (CLEAR_ON_TIMEOUT != 0) begin
            o_port <= '0;
            o_led  <= '0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_host_to_breakout.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_to_breakout
// Purpose  : Self-checking bench for host_to_breakout. The stimulus task
//            drives wire-level bits with chosen or random clock phases. A
//            frame-level model records each expected output event in a queue,
//            with the cycle in which it is due. A monitor removes an event
//            from the queue each time the DUT pulses o_valid or o_frame_err.
// Options  : H2B_PARITY_EN -- the bench adds parity bits and parity tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_to_breakout;

  localparam int RST_THRESH = 10;
  localparam int TIMEOUT    = 3000;
  localparam int CLEAR      = 1;
`ifdef H2B_PARITY_EN
  localparam int FB = 13;
`else
  localparam int FB = 12;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wclk;
  logic       q;
  logic [7:0] o_port;
  logic [3:0] o_led;
  logic       o_valid, o_frame_err, o_link_up;

  host_to_breakout #(
    .RST_THRESH       (RST_THRESH),
    .TIMEOUT_CYCLES   (TIMEOUT),
    .CLEAR_ON_TIMEOUT (CLEAR)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_wire_clk  (wclk),
    .i_q         (q),
    .o_port      (o_port),
    .o_led       (o_led),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_link_up   (o_link_up)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] port;
    logic [3:0] led;
    int         due;
  } exp_t;
  exp_t sb[$];

  // Reference model: the bits collected since the last realignment, and
  // the cycle in which the host drove the last rising edge of the wire clock.
  logic mbits[$];
  int   last_rise = -1000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Realignment: any partial frame is discarded RST_THRESH cycles after the
  // internal shift. That shift happens 3 cycles after the pin edge.
  task automatic model_realign();
    exp_t e;
    if (mbits.size() != 0) begin
      e.is_err = 1'b1; e.port = '0; e.led = '0;
      e.due = last_rise + 3 + RST_THRESH;
      sb.push_back(e);
    end
    mbits.delete();
  endtask

  task automatic model_rise(input logic b);
    exp_t       e;
    logic [12:0] w;
    logic       par;
    mbits.push_back(b);
    last_rise = cyc;
    if (mbits.size() == FB) begin
      w = '0; par = 1'b0;
      for (int i = 0; i < FB; i++) begin
        w[i] = mbits[i];
        par  = par ^ mbits[i];
      end
      e.port = w[7:0]; e.led = w[11:8]; e.due = cyc + 4;
      e.is_err = (FB == 13) && par;
      sb.push_back(e);
      mbits.delete();
    end
  endtask

  // Called just after a clk rising edge. The task drives the wire clock low
  // with the new data for 'low' cycles, then high for 'high' cycles.
  task automatic drive_bit(input logic b, input int low, input int high);
    if (cyc + low - last_rise > RST_THRESH) model_realign();
    wclk = 1'b0; q = b;
    repeat (low) begin @(posedge clk); #1; end
    wclk = 1'b1;
    model_rise(b);
    repeat (high) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [11:0] w, input logic bad_par, input int first_low,
                           input int fix_low, input int fix_high, input int kbit, input int klow);
    logic [12:0] bits;
    int lo, hi;
    bits = {(^w) ^ bad_par, w};
    for (int i = 0; i < FB; i++) begin
      lo = (i == 0) ? first_low : (i == kbit) ? klow :
           (fix_low != 0) ? fix_low : int'($urandom_range(4, 2));
      hi = (fix_high != 0) ? fix_high : int'($urandom_range(4, 2));
      drive_bit(bits[i], lo, hi);
    end
  endtask

  task automatic flush();
    model_realign();
    wclk = 1'b0;
    last_rise = -1000;
    repeat (RST_THRESH + 12) begin @(posedge clk); #1; end
  endtask

  // Monitor
  logic       mon_en = 1'b0;
  logic       prev_link = 1'b0;
  logic [7:0] prev_port = '0;
  logic [3:0] prev_led = '0;
  int         last_valid_cyc = 0;
  int         falls = 0;
  exp_t       me;

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_valid || o_frame_err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b at cycle %0d, none expected",
                   o_valid, o_frame_err, cyc);
        end else begin
          me = sb.pop_front();
          if (me.is_err) begin
            if (!o_frame_err || o_valid || cyc != me.due) begin
              errors++;
              $display("FAIL frame_err_event: got valid=%0b err=%0b at cycle %0d, expected err at cycle %0d",
                       o_valid, o_frame_err, cyc, me.due);
            end
          end else if (!o_valid || o_frame_err || cyc != me.due ||
                       o_port != me.port || o_led != me.led) begin
            errors++;
            $display("FAIL valid_event: got valid=%0b err=%0b port=%h led=%h cycle %0d, expected port=%h led=%h cycle %0d",
                     o_valid, o_frame_err, o_port, o_led, cyc, me.port, me.led, me.due);
          end
        end
      end
      if (o_valid) last_valid_cyc = cyc;
      if (o_link_up && !prev_link) begin
        checks++;
        if (!o_valid) begin
          errors++;
          $display("FAIL link_rise: link_up rose without o_valid at cycle %0d", cyc);
        end
      end
      if (!o_link_up && prev_link) begin
        falls++;
        checks++;
        if (cyc != last_valid_cyc + TIMEOUT ||
            (CLEAR != 0 && (o_port != 8'h00 || o_led != 4'h0))) begin
          errors++;
          $display("FAIL link_fall: cycle %0d port=%h led=%h, expected cycle %0d port/led cleared=%0d",
                   cyc, o_port, o_led, last_valid_cyc + TIMEOUT, CLEAR);
        end
      end
      if ((o_port != prev_port || o_led != prev_led) && !o_valid && !(prev_link && !o_link_up)) begin
        checks++;
        errors++;
        $display("FAIL spurious_output_change: port %h->%h led %h->%h at cycle %0d",
                 prev_port, o_port, prev_led, o_led, cyc);
      end
      prev_link = o_link_up;
      prev_port = o_port;
      prev_led  = o_led;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] w;
    int          r;
    logic        need_gap;
    rst_n = 1'b0; wclk = 1'b0; q = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_port", o_port, 0);
    chk("reset_led", o_led, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_frame_err", o_frame_err, 0);
    chk("reset_link_up", o_link_up, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Idle longer than the watchdog period: nothing should happen.
    repeat (TIMEOUT + 100) begin @(posedge clk); #1; end
    chk("idle_port", o_port, 0);
    chk("idle_link_up", o_link_up, 0);

    // 5-cycle wire period (clk/5), A5/9.
    send_word({4'h9, 8'hA5}, 1'b0, 3, 3, 2, -1, 0);
    repeat (8) begin @(posedge clk); #1; end
    chk("a5_port", o_port, 8'hA5);
    chk("a5_led", o_led, 4'h9);
    chk("a5_link_up", o_link_up, 1);

    // Partial frame (5 bits), a 10-cycle idle, then 3C/2.
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(1, 0)), 3, 2);
    send_word({4'h2, 8'h3C}, 1'b0, 10, 0, 0, -1, 0);
    repeat (8) begin @(posedge clk); #1; end
    chk("3c_port", o_port, 8'h3C);
    chk("3c_led", o_led, 4'h2);

    // Three frames back to back, without any gap.
    send_word({4'h1, 8'h01}, 1'b0, RST_THRESH + 2, 0, 0, -1, 0);
    send_word({4'h2, 8'h02}, 1'b0, 3, 0, 0, -1, 0);
    send_word({4'h3, 8'h03}, 1'b0, 3, 0, 0, -1, 0);
    repeat (8) begin @(posedge clk); #1; end
    chk("b2b_port", o_port, 8'h03);

    // Gap boundary: a spacing of exactly RST_THRESH keeps the frame aligned.
    // A spacing of RST_THRESH+1 realigns it mid-frame.
    send_word(12'h5C6, 1'b0, RST_THRESH + 2, 0, 2, 6, RST_THRESH - 2);
    send_word(12'hA39, 1'b0, 3, 0, 2, 6, RST_THRESH - 1);
    send_word(12'h7E1, 1'b0, RST_THRESH + 2, 0, 0, -1, 0);
    repeat (8) begin @(posedge clk); #1; end
    chk("gap_boundary_port", o_port, 8'hE1);

`ifdef H2B_PARITY_EN
    send_word({4'h0, 8'h0F}, 1'b1, RST_THRESH + 2, 0, 0, -1, 0);
    repeat (8) begin @(posedge clk); #1; end
    chk("bad_parity_port_held", o_port, 8'hE1);
    send_word({4'h0, 8'h0F}, 1'b0, 3, 0, 0, -1, 0);
    repeat (8) begin @(posedge clk); #1; end
    chk("good_parity_port", o_port, 8'h0F);
`endif

    // Randomized traffic: frames, partial frames, gaps and bad parity.
    need_gap = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(5, 0));
      if (r == 0) begin
        for (int i = 0; i < int'($urandom_range(FB - 1, 1)); i++)
          drive_bit(1'($urandom_range(1, 0)), (i == 0 && need_gap) ? RST_THRESH + 2 : 3, 2);
        need_gap = 1'b1;
      end else begin
        w = 12'($urandom);
        send_word(w, ($urandom_range(3, 0) == 0) ? 1'b1 : 1'b0,
                  (need_gap || r == 1) ? RST_THRESH - 2 + int'($urandom_range(6, 0))
                                       : int'($urandom_range(4, 2)),
                  0, 0, -1, 0);
        need_gap = 1'b0;
      end
    end
    flush();
    chk("random_link_up", o_link_up, 1);

    // Watchdog: a frame of FF, followed by silence.
    send_word({4'hC, 8'hFF}, 1'b0, RST_THRESH + 2, 0, 0, -1, 0);
    wclk = 1'b0;
    repeat (TIMEOUT + 30) begin @(posedge clk); #1; end
    chk("timeout_falls", falls, 1);
    chk("timeout_link_up", o_link_up, 0);
    chk("timeout_port", o_port, (CLEAR != 0) ? 0 : 8'hFF);

    flush();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
